axis_acq_sequencer: RTL and testbench
=====================================

Name: axis_acq_sequencer

Overview:
Acquisition controller that sequences one circular-buffer packetizer and its downstream RAM writer.
- Clears the packetizer, then enforces a minimum pre-trigger fill.
- Arms on a hardware or software trigger, drives the packetizer's sticky trigger and waits for completion.
- Publishes the buffer start position for the readout software.
- Sits between the software config/status registers and the packetizer.

Parameters:
CNTR_WIDTH, 32, width of beat counters, positions and config words; matches packetizer counter width.
CLR_CYCLES, 4, cycles pkt_aresetn is held low in CLEAR (min 1).

Ports:
aclk  in  1  clock, all logic rising-edge.
aresetn  in  1  asynchronous active-low reset.
cfg_pretrig  in  CNTR_WIDTH  beats accepted before a trigger is honoured.
cfg_posttrig  in  CNTR_WIDTH  post-trigger beat count, passed to packetizer.
cfg_timeout  in  CNTR_WIDTH  ARMED timeout in cycles (used only with macro).
start  in  1  single-cycle pulse: begin acquisition.
abort  in  1  single-cycle pulse: cancel acquisition.
ext_trigger  in  1  hardware trigger level, already in aclk domain.
sw_trigger  in  1  single-cycle software trigger pulse.
beat_strobe  in  1  one pulse per beat accepted by the packetizer (m_tvalid & m_tready).
pkt_complete  in  1  packetizer complete flag.
pkt_trigger_pos  in  CNTR_WIDTH  packetizer trigger position.
pkt_aresetn  out  1  synchronous active-low reset to packetizer.
pkt_trigger  out  1  sticky trigger to packetizer.
pkt_cfg_data  out  CNTR_WIDTH  post-trigger count to packetizer.
busy  out  1  high in any state except IDLE and DONE.
done  out  1  high in DONE.
start_pos  out  CNTR_WIDTH  oldest-sample position of the finished capture.
acq_count  out  16  completed acquisitions, wraps at 0xFFFF.

Behaviour:
- Reset values (async, all outputs/registers): state IDLE, pkt_aresetn=0, pkt_trigger=0, pkt_cfg_data=0, busy=0, done=0, start_pos=0, acq_count=0, counters 0.
- States and transitions:
  - IDLE: pkt_aresetn=0. start → CLEAR.
  - CLEAR: pkt_aresetn=0 for exactly CLR_CYCLES cycles. pkt_cfg_data latches cfg_posttrig on CLEAR entry and is held until the next CLEAR. Then → PRETRIG; pkt_aresetn=1 from PRETRIG onward.
  - PRETRIG: beat counter increments on beat_strobe. Leave when count ≥ cfg_pretrig → ARMED. With cfg_pretrig=0 this takes one cycle. Triggers in PRETRIG are discarded, not latched.
  - ARMED: trigger event = rising edge of ext_trigger (registered previous value; edge detector updates every cycle in every state), or sw_trigger=1. On event → CAPTURE.
  - CAPTURE: pkt_trigger=1, held until the next CLEAR. On pkt_complete=1 → DONE.
  - DONE: entry cycle sets start_pos = (pkt_trigger_pos − cfg_pretrig) mod 2^CNTR_WIDTH and increments acq_count. start → CLEAR (re-acquire).
- Outputs: busy is registered, =1 in CLEAR, PRETRIG, ARMED, CAPTURE.
- Latency: start to pkt_aresetn rising = CLR_CYCLES+1 cycles. Trigger edge to pkt_trigger=1 = 1 cycle. pkt_complete to done=1 = 1 cycle.
- abort in CLEAR, PRETRIG, ARMED or CAPTURE → IDLE next cycle. pkt_trigger cleared, start_pos and acq_count unchanged.
- abort and start in the same cycle: abort wins.
- start while busy: ignored.
- abort in IDLE or DONE: DONE → IDLE, IDLE unchanged.
- Trigger and abort in the same ARMED cycle: abort wins.
- pkt_complete seen in a state other than CAPTURE: ignored.

Optional Feature:
ACQ_SEQ_TIMEOUT_EN.
- Defined: a cycle counter runs in ARMED. When it reaches cfg_timeout (≠0) with no trigger, the block forces the trigger exactly as a real event and sets a sticky status bit forced_trig, driven on an extra output port forced_trig (1 bit, reset 0, cleared on CLEAR entry). cfg_timeout=0 disables the timeout.
- Undefined: no counter, no forced_trig port, and cfg_timeout is ignored.

Decomposition:
- Shared package: state enum (IDLE, CLEAR, PRETRIG, ARMED, CAPTURE, DONE), default CNTR_WIDTH, ACQ_COUNT_WIDTH=16.
- One sub-module, acq_trig_detect: edge detect plus OR with sw_trigger, gated by an arm input. It also hosts the timeout counter under the macro.

Test Plan:
- Basic: CLR_CYCLES=4, cfg_pretrig=8, cfg_posttrig=16. start; 8 beats; ext_trigger rises; packetizer model completes with trigger_pos=40 → pkt_aresetn low exactly 4 cycles; pkt_trigger is 0 until the 8th beat and rises 1 cycle after the edge; done=1 one cycle after complete; start_pos=32; acq_count=1.
- Early trigger: ext_trigger rises after beat 3 of 8 and stays high → no capture. A later sw_trigger pulse in ARMED → CAPTURE next cycle.
- Wrap: CNTR_WIDTH=8, cfg_pretrig=10, trigger_pos=4 → start_pos=250.
- Abort race: abort together with a trigger in ARMED → IDLE, pkt_trigger stays 0, acq_count unchanged. Abort together with start in DONE → IDLE.
- Re-arm: start in DONE → CLEAR; pkt_trigger drops and pkt_cfg_data reloads the new cfg_posttrig=32. A second completion → acq_count=2.
- Async reset asserted mid-CAPTURE → all outputs reset values immediately, with no clock edge needed. With ACQ_SEQ_TIMEOUT_EN and cfg_timeout=100, no trigger → forced trigger 100 cycles after ARMED entry, forced_trig=1.

Source files
------------

// File: rtl/axis_acq_sequencer_pkg.sv
// Shared types and constants for the acquisition sequencer.
package axis_acq_sequencer_pkg;

  localparam int ACQ_CNTR_WIDTH_DEF = 32;
  localparam int ACQ_COUNT_WIDTH    = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_PRETRIG = 3'd2,
    ST_ARMED   = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_DONE    = 3'd5
  } acq_state_t;

  function automatic logic acq_is_busy(input acq_state_t s);
    return (s == ST_CLEAR) || (s == ST_PRETRIG) || (s == ST_ARMED) || (s == ST_CAPTURE);
  endfunction

endpackage

// File: rtl/acq_trig_detect.sv
// Trigger qualifier: rising-edge detect on ext_trigger, OR with sw_trigger,
// gated by arm. Optional macro ACQ_SEQ_TIMEOUT_EN adds an armed-dwell timeout
// that forces a trigger after cfg_timeout cycles (0 disables it).
module acq_trig_detect
  import axis_acq_sequencer_pkg::*;
`ifdef ACQ_SEQ_TIMEOUT_EN
#(
  parameter int CNTR_WIDTH = ACQ_CNTR_WIDTH_DEF
)
`endif
(
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  arm,
  input  logic                  ext_trigger,
  input  logic                  sw_trigger,
`ifdef ACQ_SEQ_TIMEOUT_EN
  input  logic [CNTR_WIDTH-1:0] cfg_timeout,
  output logic                  trig_forced,
`endif
  output logic                  trig_event
);

  logic ext_trigger_p1;
  logic ext_rise;

  // Previous ext_trigger level, tracked in every state so a level already high on arming is not an edge.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ext_trigger_p1 <= 1'b0;
    end else begin
      ext_trigger_p1 <= ext_trigger;
    end
  end

  assign ext_rise = ext_trigger & ~ext_trigger_p1;

`ifdef ACQ_SEQ_TIMEOUT_EN
  logic [CNTR_WIDTH-1:0] tmo_cnt;
  logic                  tmo_hit;

  // Cycles spent armed; restarts whenever the sequencer leaves ARMED.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tmo_cnt <= '0;
    end else if (arm) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end

  // Fires on the cfg_timeout-th armed cycle, so the capture starts cfg_timeout cycles after arming.
  assign tmo_hit     = (cfg_timeout != '0) && (tmo_cnt == cfg_timeout - 1'b1);
  assign trig_forced = arm & tmo_hit & ~(ext_rise | sw_trigger);
  assign trig_event  = arm & (ext_rise | sw_trigger | tmo_hit);
`else
  assign trig_event  = arm & (ext_rise | sw_trigger);
`endif

endmodule

// File: rtl/axis_acq_sequencer.sv
// Acquisition sequencer for a circular-buffer packetizer: clear, pre-trigger
// fill, arm, capture, publish start position. Optional macro
// ACQ_SEQ_TIMEOUT_EN adds the ARMED timeout and the forced_trig status port.
module axis_acq_sequencer
  import axis_acq_sequencer_pkg::*;
#(
  parameter int CNTR_WIDTH = ACQ_CNTR_WIDTH_DEF,
  parameter int CLR_CYCLES = 4
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [CNTR_WIDTH-1:0]      cfg_pretrig,
  input  logic [CNTR_WIDTH-1:0]      cfg_posttrig,
  input  logic [CNTR_WIDTH-1:0]      cfg_timeout,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       ext_trigger,
  input  logic                       sw_trigger,
  input  logic                       beat_strobe,
  input  logic                       pkt_complete,
  input  logic [CNTR_WIDTH-1:0]      pkt_trigger_pos,
  output logic                       pkt_aresetn,
  output logic                       pkt_trigger,
  output logic [CNTR_WIDTH-1:0]      pkt_cfg_data,
  output logic                       busy,
  output logic                       done,
  output logic [CNTR_WIDTH-1:0]      start_pos,
`ifdef ACQ_SEQ_TIMEOUT_EN
  output logic                       forced_trig,
`endif
  output logic [ACQ_COUNT_WIDTH-1:0] acq_count
);

  localparam int              CLR_W    = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);

  acq_state_t            state;
  acq_state_t            state_n;
  logic [CLR_W-1:0]      clr_cnt;
  logic [CNTR_WIDTH-1:0] beat_cnt;
  logic                  arm;
  logic                  trig_event;
  logic                  entering_clear;
  logic                  finishing;

  // Oldest-sample position: trigger position minus the pre-trigger depth, modulo the counter width.
  function automatic logic [CNTR_WIDTH-1:0] wrap_sub(input logic [CNTR_WIDTH-1:0] a,
                                                     input logic [CNTR_WIDTH-1:0] b);
    return a - b;
  endfunction

  assign arm = (state == ST_ARMED);

`ifdef ACQ_SEQ_TIMEOUT_EN
  logic trig_forced;

  acq_trig_detect #(
    .CNTR_WIDTH (CNTR_WIDTH)
  ) u_trig (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .arm         (arm),
    .ext_trigger (ext_trigger),
    .sw_trigger  (sw_trigger),
    .cfg_timeout (cfg_timeout),
    .trig_forced (trig_forced),
    .trig_event  (trig_event)
  );
`else
  logic unused_cfg_timeout;
  assign unused_cfg_timeout = ^cfg_timeout;

  acq_trig_detect u_trig (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .arm         (arm),
    .ext_trigger (ext_trigger),
    .sw_trigger  (sw_trigger),
    .trig_event  (trig_event)
  );
`endif

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic; abort takes priority over every other request.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:    if (start && !abort)              state_n = ST_CLEAR;
      ST_CLEAR:   if (abort)                        state_n = ST_IDLE;
                  else if (clr_cnt == CLR_LAST)     state_n = ST_PRETRIG;
      ST_PRETRIG: if (abort)                        state_n = ST_IDLE;
                  else if (beat_cnt >= cfg_pretrig) state_n = ST_ARMED;
      ST_ARMED:   if (abort)                        state_n = ST_IDLE;
                  else if (trig_event)              state_n = ST_CAPTURE;
      ST_CAPTURE: if (abort)                        state_n = ST_IDLE;
                  else if (pkt_complete)            state_n = ST_DONE;
      ST_DONE:    if (abort)                        state_n = ST_IDLE;
                  else if (start)                   state_n = ST_CLEAR;
      default:                                      state_n = ST_IDLE;
    endcase
  end

  assign entering_clear = (state_n == ST_CLEAR) && (state != ST_CLEAR);
  assign finishing      = (state == ST_CAPTURE) && (state_n == ST_DONE);

  // Clear-duration and pre-trigger beat counters, both idle at zero outside their state.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      clr_cnt  <= '0;
      beat_cnt <= '0;
    end else begin
      clr_cnt <= (state == ST_CLEAR) ? clr_cnt + 1'b1 : '0;
      if (state == ST_PRETRIG) begin
        if (beat_strobe) beat_cnt <= beat_cnt + 1'b1;
      end else begin
        beat_cnt <= '0;
      end
    end
  end

  // Registered outputs derived from the state being entered.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_aresetn  <= 1'b0;
      pkt_trigger  <= 1'b0;
      pkt_cfg_data <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      start_pos    <= '0;
      acq_count    <= '0;
    end else begin
      pkt_aresetn <= !((state_n == ST_IDLE) || (state_n == ST_CLEAR));
      busy        <= acq_is_busy(state_n);
      done        <= (state_n == ST_DONE);
      if (entering_clear) pkt_cfg_data <= cfg_posttrig;
      // Sticky until the next clear; an abort from an active state also drops it.
      if (state_n == ST_CAPTURE) begin
        pkt_trigger <= 1'b1;
      end else if ((state_n == ST_CLEAR) || (acq_is_busy(state) && (state_n == ST_IDLE))) begin
        pkt_trigger <= 1'b0;
      end
      if (finishing) begin
        start_pos <= wrap_sub(pkt_trigger_pos, cfg_pretrig);
        acq_count <= acq_count + 1'b1;
      end
    end
  end

`ifdef ACQ_SEQ_TIMEOUT_EN
  // Sticky record that the last capture was started by the timeout, not a real trigger.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      forced_trig <= 1'b0;
    end else if (entering_clear) begin
      forced_trig <= 1'b0;
    end else if (arm && (state_n == ST_CAPTURE) && trig_forced) begin
      forced_trig <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_acq_sequencer.sv
// Bench for axis_acq_sequencer: table of full acquisitions, hand-written
// corner sequences, then random stimulus against a behavioural model.
module tb_axis_acq_sequencer;

  localparam int CLR = 4;

  logic        aclk;
  logic        aresetn;
  logic [31:0] cfg_pretrig, cfg_posttrig, cfg_timeout, pkt_trigger_pos;
  logic        start, abort, ext_trigger, sw_trigger, beat_strobe, pkt_complete;
  logic        pkt_aresetn, pkt_trigger, busy, done;
  logic [31:0] pkt_cfg_data, start_pos;
  logic [15:0] acq_count;
  logic        pkt_aresetn8, pkt_trigger8, busy8, done8;
  logic [7:0]  pkt_cfg_data8, start_pos8;
  logic [15:0] acq_count8;
`ifdef ACQ_SEQ_TIMEOUT_EN
  logic        forced_trig, forced_trig8;
`endif

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  axis_acq_sequencer #(.CNTR_WIDTH(32), .CLR_CYCLES(CLR)) u_dut (
    .aclk(aclk), .aresetn(aresetn),
    .cfg_pretrig(cfg_pretrig), .cfg_posttrig(cfg_posttrig), .cfg_timeout(cfg_timeout),
    .start(start), .abort(abort), .ext_trigger(ext_trigger), .sw_trigger(sw_trigger),
    .beat_strobe(beat_strobe), .pkt_complete(pkt_complete), .pkt_trigger_pos(pkt_trigger_pos),
    .pkt_aresetn(pkt_aresetn), .pkt_trigger(pkt_trigger), .pkt_cfg_data(pkt_cfg_data),
    .busy(busy), .done(done), .start_pos(start_pos),
`ifdef ACQ_SEQ_TIMEOUT_EN
    .forced_trig(forced_trig),
`endif
    .acq_count(acq_count)
  );

  axis_acq_sequencer #(.CNTR_WIDTH(8), .CLR_CYCLES(CLR)) u_dut8 (
    .aclk(aclk), .aresetn(aresetn),
    .cfg_pretrig(cfg_pretrig[7:0]), .cfg_posttrig(cfg_posttrig[7:0]), .cfg_timeout(cfg_timeout[7:0]),
    .start(start), .abort(abort), .ext_trigger(ext_trigger), .sw_trigger(sw_trigger),
    .beat_strobe(beat_strobe), .pkt_complete(pkt_complete), .pkt_trigger_pos(pkt_trigger_pos[7:0]),
    .pkt_aresetn(pkt_aresetn8), .pkt_trigger(pkt_trigger8), .pkt_cfg_data(pkt_cfg_data8),
    .busy(busy8), .done(done8), .start_pos(start_pos8),
`ifdef ACQ_SEQ_TIMEOUT_EN
    .forced_trig(forced_trig8),
`endif
    .acq_count(acq_count8)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural reference ----------------
  typedef enum int {P_IDLE, P_CLEAR, P_PRE, P_ARMED, P_CAP, P_DONE} phase_t;
  phase_t      m_phase;
  int          m_clear_left;
  int unsigned m_beats, m_wait;
  logic        m_ext_prev, m_trig;
  logic [31:0] m_cfg, m_start_pos;
  logic [15:0] m_count;
`ifdef ACQ_SEQ_TIMEOUT_EN
  logic        m_forced;
`endif

  task automatic model_reset();
    m_phase = P_IDLE; m_clear_left = 0; m_beats = 0; m_wait = 0;
    m_ext_prev = 0; m_trig = 0; m_cfg = 0; m_start_pos = 0; m_count = 0;
`ifdef ACQ_SEQ_TIMEOUT_EN
    m_forced = 0;
`endif
  endtask

  task automatic enter_clear();
    m_phase = P_CLEAR; m_clear_left = CLR; m_cfg = cfg_posttrig; m_trig = 0;
`ifdef ACQ_SEQ_TIMEOUT_EN
    m_forced = 0;
`endif
  endtask

  task automatic model_step();
    logic edge_seen, hit;
    if (!aresetn) begin model_reset(); return; end
    edge_seen = ext_trigger && !m_ext_prev;
    m_ext_prev = ext_trigger;
    if (abort) begin
      if (m_phase inside {P_CLEAR, P_PRE, P_ARMED, P_CAP}) m_trig = 0;
      m_phase = P_IDLE;
    end else begin
      case (m_phase)
        P_IDLE:  if (start) enter_clear();
        P_CLEAR: begin
          m_clear_left--;
          if (m_clear_left == 0) begin m_phase = P_PRE; m_beats = 0; end
        end
        P_PRE: begin
          if (m_beats >= cfg_pretrig) begin m_phase = P_ARMED; m_wait = 0; end
          else if (beat_strobe) m_beats++;
        end
        P_ARMED: begin
          m_wait++;
          hit = 0;
`ifdef ACQ_SEQ_TIMEOUT_EN
          hit = (cfg_timeout != 0) && (m_wait == cfg_timeout);
`endif
          if (edge_seen || sw_trigger || hit) begin
            m_phase = P_CAP; m_trig = 1;
`ifdef ACQ_SEQ_TIMEOUT_EN
            if (!edge_seen && !sw_trigger) m_forced = 1;
`endif
          end
        end
        P_CAP: if (pkt_complete) begin
          m_phase = P_DONE;
          m_start_pos = pkt_trigger_pos - cfg_pretrig;
          m_count = m_count + 16'd1;
        end
        P_DONE: if (start) enter_clear();
        default: m_phase = P_IDLE;
      endcase
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_all();
    chk("m_pkt_aresetn", pkt_aresetn, m_phase inside {P_PRE, P_ARMED, P_CAP, P_DONE});
    chk("m_busy", busy, m_phase inside {P_CLEAR, P_PRE, P_ARMED, P_CAP});
    chk("m_done", done, m_phase == P_DONE);
    chk("m_pkt_trigger", pkt_trigger, m_trig);
    chk("m_pkt_cfg_data", pkt_cfg_data, m_cfg);
    chk("m_start_pos", start_pos, m_start_pos);
    chk("m_acq_count", acq_count, m_count);
`ifdef ACQ_SEQ_TIMEOUT_EN
    chk("m_forced_trig", forced_trig, m_forced);
`endif
  endtask

  task automatic tick();
    @(posedge aclk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic cyc(input logic st, input logic ab, input logic sw, input logic bt, input logic cp);
    start = st; abort = ab; sw_trigger = sw; beat_strobe = bt; pkt_complete = cp;
    tick();
    start = 0; abort = 0; sw_trigger = 0; beat_strobe = 0; pkt_complete = 0;
  endtask

  // Start, sit out the clear, return once the packetizer is out of reset.
  task automatic begin_acq(input logic [31:0] pre, input logic [31:0] post);
    int n;
    cfg_pretrig = pre; cfg_posttrig = post;
    cyc(1, 0, 0, 0, 0);
    chk("cfg_load", pkt_cfg_data, post);
    chk("trig_cleared", pkt_trigger, 0);
    chk("busy_clear", busy, 1);
    n = 0;
    while (!pkt_aresetn && n < 20) begin n++; cyc(0, 0, 0, 0, 0); end
    chk("clr_len", n, CLR);
  endtask

  task automatic run_acq(input logic [31:0] pre, input logic [31:0] tpos, input logic [31:0] post);
    pkt_trigger_pos = tpos;
    begin_acq(pre, post);
    for (int b = 0; b < int'(pre); b++) begin
      chk("trig_early", pkt_trigger, 0);
      cyc(0, 0, 0, 1, 0);
    end
    cyc(0, 0, 0, 0, 0);
    chk("trig_before_edge", pkt_trigger, 0);
    chk("busy_armed", busy, 1);
    ext_trigger = 1;
    cyc(0, 0, 0, 0, 0);
    chk("trig_latency", pkt_trigger, 1);
    ext_trigger = 0;
    repeat (3) cyc(0, 0, 0, 0, 0);
    chk("done_before_complete", done, 0);
    cyc(0, 0, 0, 0, 1);
    exp_cnt++;
    chk("done_latency", done, 1);
    chk("busy_done", busy, 0);
    chk("acq_count", acq_count, exp_cnt);
  endtask

  typedef struct {
    logic [31:0] pre;
    logic [31:0] tpos;
    logic [31:0] post;
    logic [31:0] exp32;
    logic [7:0]  exp8;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int n;
    vecs[0] = '{pre: 32'd8,  tpos: 32'd40,  post: 32'd16, exp32: 32'd32,         exp8: 8'd32};
    vecs[1] = '{pre: 32'd10, tpos: 32'd4,   post: 32'd5,  exp32: 32'hFFFF_FFFA,  exp8: 8'd250};
    vecs[2] = '{pre: 32'd0,  tpos: 32'd7,   post: 32'd1,  exp32: 32'd7,          exp8: 8'd7};
    vecs[3] = '{pre: 32'd3,  tpos: 32'd3,   post: 32'd2,  exp32: 32'd0,          exp8: 8'd0};
    vecs[4] = '{pre: 32'd5,  tpos: 32'd2,   post: 32'd9,  exp32: 32'hFFFF_FFFD,  exp8: 8'd253};
    vecs[5] = '{pre: 32'd2,  tpos: 32'd100, post: 32'd32, exp32: 32'd98,         exp8: 8'd98};

    aresetn = 0; start = 0; abort = 0; ext_trigger = 0; sw_trigger = 0;
    beat_strobe = 0; pkt_complete = 0; cfg_pretrig = 0; cfg_posttrig = 0;
    cfg_timeout = 0; pkt_trigger_pos = 0;
    model_reset();
    repeat (3) tick();
    chk("rst_pkt_aresetn", pkt_aresetn, 0);
    chk("rst_busy", busy, 0);
    chk("rst_acq_count", acq_count, 0);
    aresetn = 1;
    repeat (2) cyc(0, 0, 0, 0, 0);

    // Table of complete acquisitions, back to back (each later one restarts from DONE).
    for (int i = 0; i < 6; i++) begin
      run_acq(vecs[i].pre, vecs[i].tpos, vecs[i].post);
      chk("start_pos", start_pos, vecs[i].exp32);
      chk("start_pos8", start_pos8, vecs[i].exp8);
      chk("cfg8", pkt_cfg_data8, vecs[i].post[7:0]);
      chk("done8", done8, 1);
      chk("busy8", busy8, 0);
      chk("aresetn8", pkt_aresetn8, 1);
      chk("trig8", pkt_trigger8, 1);
      chk("acq_count8", acq_count8, exp_cnt);
    end

    // Early trigger: level rises during pre-fill and stays high; only a later sw pulse captures.
    pkt_trigger_pos = 32'd20;
    begin_acq(32'd8, 32'd16);
    for (int b = 0; b < 8; b++) begin
      if (b == 3) ext_trigger = 1;
      cyc(0, 0, 0, 1, 0);
    end
    repeat (4) begin
      cyc(0, 0, 0, 0, 0);
      chk("early_no_trig", pkt_trigger, 0);
      chk("early_busy", busy, 1);
    end
    cyc(0, 0, 1, 0, 0);
    chk("sw_trig_latency", pkt_trigger, 1);
    ext_trigger = 0;
    cyc(0, 0, 0, 0, 1);
    exp_cnt++;
    chk("early_start_pos", start_pos, 32'd12);
    chk("early_count", acq_count, exp_cnt);

    // Abort racing a trigger edge in ARMED.
    begin_acq(32'd0, 32'd16);
    cyc(0, 0, 0, 0, 0);
    ext_trigger = 1;
    cyc(0, 1, 0, 0, 0);
    chk("abort_busy", busy, 0);
    chk("abort_trig", pkt_trigger, 0);
    chk("abort_rstn", pkt_aresetn, 0);
    chk("abort_count", acq_count, exp_cnt);
    ext_trigger = 0;
    repeat (2) cyc(0, 0, 0, 0, 0);

    // Abort together with start in DONE.
    run_acq(32'd1, 32'd50, 32'd16);
    cyc(1, 1, 0, 0, 0);
    chk("done_abort_done", done, 0);
    chk("done_abort_busy", busy, 0);
    chk("done_abort_rstn", pkt_aresetn, 0);
    chk("done_abort_count", acq_count, exp_cnt);

    // Asynchronous reset in the middle of CAPTURE.
    begin_acq(32'd0, 32'd16);
    cyc(0, 0, 0, 0, 0);
    ext_trigger = 1;
    cyc(0, 0, 0, 0, 0);
    chk("cap_trig", pkt_trigger, 1);
    ext_trigger = 0;
    cyc(0, 0, 0, 0, 0);
    #2;
    aresetn = 0;
    #1;
    chk("arst_rstn", pkt_aresetn, 0);
    chk("arst_trig", pkt_trigger, 0);
    chk("arst_cfg", pkt_cfg_data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_start_pos", start_pos, 0);
    chk("arst_count", acq_count, 0);
    model_reset();
    exp_cnt = 0;
    repeat (2) cyc(0, 0, 0, 0, 0);
    aresetn = 1;
    cyc(0, 0, 0, 0, 0);

    // ARMED timeout with no trigger.
    cfg_timeout = 32'd100;
    begin_acq(32'd0, 32'd16);
    cyc(0, 0, 0, 0, 0);
    n = 0;
    while (!pkt_trigger && n < 300) begin n++; cyc(0, 0, 0, 0, 0); end
`ifdef ACQ_SEQ_TIMEOUT_EN
    chk("timeout_cycles", n, 100);
    chk("forced_trig", forced_trig, 1);
    chk("forced_trig8", forced_trig8, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0);
    chk("forced_cleared", forced_trig, 0);
`else
    chk("no_timeout", pkt_trigger, 0);
`endif
    cyc(0, 1, 0, 0, 0);
    cfg_timeout = 0;

    // Random stimulus against the reference model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 3) cfg_pretrig = $urandom_range(0, 12);
      if ($urandom_range(0, 99) < 3) cfg_posttrig = $urandom;
      if ($urandom_range(0, 99) < 3) cfg_timeout = $urandom_range(0, 30);
      if ($urandom_range(0, 9) == 0) ext_trigger = ~ext_trigger;
      pkt_trigger_pos = $urandom;
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0,
          $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
